// File: rtl/button_conditioner.sv
// Debounces a raw active-high input and derives clean edge and long-press pulses.
// A 2-flop synchronizer feeds a four-state debounce FSM. A hold counter measures
// how long the accepted level has been high. Every output comes straight from a flop.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOW       | accepted level 0, waiting for s to go high
// WAIT_HIGH | s high, counting toward DEBOUNCE_P before accepting 1
// HIGH      | accepted level 1, hold counter running
// WAIT_LOW  | s low, counting toward DEBOUNCE_P before accepting 0
module button_conditioner #(
  parameter int unsigned DEBOUNCE_P   = 300,
  parameter int unsigned LONG_PRESS_T = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_P - 1);
  localparam logic [15:0] HOLD_MAX  = 16'(LONG_PRESS_T);
  localparam logic [15:0] HOLD_LAST = 16'(LONG_PRESS_T - 1);
  // With DEBOUNCE_P = 1 the stable state accepts a change directly. This keeps the
  // latency from the first sample of the new value to the level change at DEBOUNCE_P+2 edges.
  localparam bit DIRECT = (DEBOUNCE_P == 1);

  logic        sync_a;
  logic        s;
  state_t      state, state_n;
  logic [15:0] deb_cnt, deb_n;
  logic [15:0] hold_cnt, hold_n;
  logic        level_n, rise_n, fall_n, long_n;

  // Two-flop synchronizer; only s is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= din;
      s      <= sync_a;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOW;
      deb_cnt    <= 16'd0;
      hold_cnt   <= 16'd0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_n;
      deb_cnt    <= deb_n;
      hold_cnt   <= hold_n;
      level      <= level_n;
      rise       <= rise_n;
      fall       <= fall_n;
      long_press <= long_n;
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    hold_n  = hold_cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    long_n  = 1'b0;

    // While the accepted level is high, hold time keeps accumulating. This
    // includes bounces inside WAIT_LOW. The count saturates so that long_press fires only once.
    if (state == HIGH || state == WAIT_LOW) begin
      if (hold_cnt < HOLD_MAX) begin
        hold_n = hold_cnt + 16'd1;
      end
      long_n = (hold_cnt == HOLD_LAST);
    end

    case (state)
      LOW: begin
        hold_n = 16'd0;
        if (s) begin
          if (DIRECT) begin
            state_n = HIGH;
            deb_n   = 16'd0;
            rise_n  = 1'b1;
          end else begin
            state_n = WAIT_HIGH;
            deb_n   = 16'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_n = LOW;
          deb_n   = 16'd0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n = HIGH;
          deb_n   = 16'd0;
          hold_n  = 16'd0;
          rise_n  = 1'b1;
        end else begin
          deb_n = deb_cnt + 16'd1;
        end
      end
      HIGH: begin
        if (!s) begin
          if (DIRECT) begin
            state_n = LOW;
            deb_n   = 16'd0;
            fall_n  = 1'b1;
          end else begin
            state_n = WAIT_LOW;
            deb_n   = 16'd1;
          end
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = HIGH;
          deb_n   = 16'd0;
        end else if (deb_cnt >= DEB_LAST) begin
          state_n = LOW;
          deb_n   = 16'd0;
          fall_n  = 1'b1;
        end else begin
          deb_n = deb_cnt + 16'd1;
        end
      end
      default: begin
        state_n = LOW;
        deb_n   = 16'd0;
        hold_n  = 16'd0;
      end
    endcase

    level_n = (state_n == HIGH) || (state_n == WAIT_LOW);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner. Scenarios push the expected pulse events into
// per-DUT queues. A monitor pops an entry and compares it whenever a pulse appears.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst, din, din1;
  logic level, rise, fall, long_press;
  logic level1, rise1, fall1, long_press1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  button_conditioner #(.DEBOUNCE_P(4), .LONG_PRESS_T(10)) dut (
    .clk(clk), .rst(rst), .din(din),
    .level(level), .rise(rise), .fall(fall), .long_press(long_press)
  );

  button_conditioner #(.DEBOUNCE_P(1), .LONG_PRESS_T(10)) dut1 (
    .clk(clk), .rst(rst), .din(din1),
    .level(level1), .rise(rise1), .fall(fall1), .long_press(long_press1)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n, cyc == n when sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "rise";
      1: return "fall";
      default: return "long_press";
    endcase
  endfunction

  task automatic expect_ev(input int dutn, input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    if (dutn == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic pop_check(input int dutn, input int kind);
    ev_t e;
    checks++;
    if ((dutn == 0 && q0.size() == 0) || (dutn == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_pulse dut%0d: got %s at cycle %0d, required no pulse",
               dutn, kname(kind), cyc);
    end else begin
      e = (dutn == 0) ? q0.pop_front() : q1.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        failures++;
        $display("FAIL pulse_event dut%0d: got %s at cycle %0d, required %s at cycle %0d",
                 dutn, kname(kind), cyc, kname(e.kind), e.at);
      end
    end
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rise === 1'b1) pop_check(0, 0);
    if (fall === 1'b1) pop_check(0, 1);
    if (long_press === 1'b1) pop_check(0, 2);
    if (rise1 === 1'b1) pop_check(1, 0);
    if (fall1 === 1'b1) pop_check(1, 1);
    if (long_press1 === 1'b1) pop_check(1, 2);
  end

  task automatic check_val(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d/%0d expected pulses never seen, required 0/0",
               name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int b;
    rst  = 1'b1;
    din  = 1'b0;
    din1 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_level", level, 1'b0);
    check_val("reset_rise", rise, 1'b0);
    check_val("reset_fall", fall, 1'b0);
    check_val("reset_long", long_press, 1'b0);
    check_val("reset_level1", level1, 1'b0);

    // Clean press held 20 cycles, then release.
    b = cyc;
    rst = 1'b0;
    din = 1'b1;
    expect_ev(0, 0, b + 6);
    expect_ev(0, 2, b + 16);
    wait_to(b + 5);  check_val("press_level_before", level, 1'b0);
    wait_to(b + 6);  check_val("press_level_after", level, 1'b1);
                     check_val("press_rise", rise, 1'b1);
    wait_to(b + 7);  check_val("press_rise_drop", rise, 1'b0);
    wait_to(b + 20);
    din = 1'b0;
    b = cyc;
    expect_ev(0, 1, b + 6);
    wait_to(b + 5);  check_val("release_level_before", level, 1'b1);
    wait_to(b + 6);  check_val("release_level_after", level, 1'b0);
    wait_to(b + 10); check_empty("press_release_events");

    // Short glitches: 3 high, 5 low, 3 high.
    b = cyc;
    din = 1'b1;
    wait_to(b + 3);  din = 1'b0;
    wait_to(b + 7);  check_val("glitch_level_a", level, 1'b0);
    wait_to(b + 8);  din = 1'b1;
    wait_to(b + 11); din = 1'b0;
    wait_to(b + 14); check_val("glitch_level_b", level, 1'b0);
    wait_to(b + 25); check_empty("glitch_events");

    // Press, 2-cycle dip, then final release; dip must not reset hold time.
    b = cyc;
    din = 1'b1;
    expect_ev(0, 0, b + 6);
    expect_ev(0, 2, b + 16);
    expect_ev(0, 1, b + 18);
    wait_to(b + 8);  din = 1'b0;
    wait_to(b + 10); din = 1'b1;
    wait_to(b + 12); din = 1'b0;
    wait_to(b + 14); check_val("dip_level_held", level, 1'b1);
    wait_to(b + 17); check_val("dip_level_before_fall", level, 1'b1);
    wait_to(b + 18); check_val("dip_level_after_fall", level, 1'b0);
    wait_to(b + 24); check_empty("dip_events");

    // long_press and fall in the same cycle.
    b = cyc;
    din = 1'b1;
    expect_ev(0, 0, b + 6);
    expect_ev(0, 1, b + 16);
    expect_ev(0, 2, b + 16);
    wait_to(b + 10); din = 1'b0;
    wait_to(b + 16); check_val("coincide_fall", fall, 1'b1);
                     check_val("coincide_long", long_press, 1'b1);
    wait_to(b + 22); check_empty("coincide_events");

    // Reset in the middle of a press with din still high.
    b = cyc;
    din = 1'b1;
    expect_ev(0, 0, b + 6);
    expect_ev(0, 0, b + 15);
    expect_ev(0, 2, b + 25);
    expect_ev(0, 1, b + 33);
    wait_to(b + 8);  check_val("midreset_level_pre", level, 1'b1);
    rst = 1'b1;
    wait_to(b + 9);  check_val("midreset_level", level, 1'b0);
                     check_val("midreset_fall", fall, 1'b0);
                     check_val("midreset_rise", rise, 1'b0);
    rst = 1'b0;
    wait_to(b + 14); check_val("rerelease_level_before", level, 1'b0);
    wait_to(b + 15); check_val("rerelease_level_after", level, 1'b1);
    wait_to(b + 27); din = 1'b0;
    wait_to(b + 40); check_empty("midreset_events");

    // DEBOUNCE_P = 1 instance: a single-cycle pulse is accepted for one cycle.
    b = cyc;
    din1 = 1'b1;
    expect_ev(1, 0, b + 3);
    expect_ev(1, 1, b + 4);
    wait_to(b + 1);  din1 = 1'b0;
    wait_to(b + 2);  check_val("p1_level_before", level1, 1'b0);
    wait_to(b + 3);  check_val("p1_level_high", level1, 1'b1);
    wait_to(b + 4);  check_val("p1_level_low", level1, 1'b0);
    wait_to(b + 10); check_empty("p1_events");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
